// File: rtl/sa_skew_feeder.sv
// West-edge feeder for a ROW x COL systolic array: per-row skew pipes (row r delayed r+1 registers),
// valid/ready intake, global stall, and an end-of-tile drain that ends with a one-cycle done pulse.
module sa_skew_feeder #(
  parameter int unsigned ROW       = 9,
  parameter int unsigned COL       = 1,
  parameter int unsigned DW        = 8,
  parameter int unsigned ARRAY_LAT = ROW + COL - 1
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  input  logic [ROW*DW-1:0]     in_west,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic                  in_stall,
  output logic                  o_ready,
  output logic [ROW*(DW+1)-1:0] out_west,
  output logic                  o_last_row_valid,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned LW = DW + 1;
  localparam int unsigned CW = $clog2(ROW + ARRAY_LAT + 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(ROW + ARRAY_LAT - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, done_q;
  logic          acc;

  always_comb o_ready = !in_stall && (state_q == IDLE || state_q == STREAM);
  assign acc = in_valid && o_ready;

  // Each row keeps its stages in one packed vector: stage 0 at the LSBs, oldest stage at the MSBs.
  for (genvar r = 0; r < ROW; r++) begin : g_row
    logic [LW-1:0]         lane_in;
    logic [(r+1)*LW-1:0]   stg_q, stg_d;

    assign lane_in = {acc, acc ? in_west[(ROW-r)*DW-1 -: DW] : {DW{1'b0}}};

    if (r == 0) begin : g_first
      assign stg_d = lane_in;
    end else begin : g_chain
      assign stg_d = {stg_q[r*LW-1:0], lane_in};
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
        stg_q <= '0;
      end else if (!in_stall) begin
        stg_q <= stg_d;
      end
    end

    assign out_west[(ROW-r)*LW-1 -: LW] = stg_q[(r+1)*LW-1 -: LW];
  end

  assign o_last_row_valid = out_west[DW];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, STREAM: begin
        if (acc) begin
          if (in_last) begin
            state_d = DRAIN;
            cnt_d   = DRAIN_LOAD;
          end else begin
            state_d = STREAM;
          end
        end
      end
      DRAIN: begin
        if (!in_stall) begin
          if (cnt_q == '0) state_d = DONE;
          else             cnt_d   = cnt_q - CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they leave the block glitch-free.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == STREAM) || (state_d == DRAIN);
      done_q  <= (state_d == DONE);
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule
